// File: rtl/fifo_sync_prog_pkg.sv
// Shared helpers for fifo_sync_prog: pointer width, threshold legality, count type.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package fifo_sync_pkg;

  // Depth exponent of the default configuration.
  localparam int DEFAULT_ADDR_BITS = 4;

  // One extra MSB lets the pointers tell "full" apart from "empty".
  function automatic int ptr_width(input int addr_bits);
    return addr_bits + 1;
  endfunction

  // almost_full threshold must be reachable and non-trivial: 1..DEPTH.
  function automatic bit af_thresh_ok(input int thresh, input int addr_bits);
    return (thresh >= 1) && (thresh <= (1 << addr_bits));
  endfunction

  // almost_empty threshold: 0..DEPTH-1.
  function automatic bit ae_thresh_ok(input int thresh, input int addr_bits);
    return (thresh >= 0) && (thresh <= (1 << addr_bits) - 1);
  endfunction

  // Occupancy type for the default configuration (0..DEPTH needs ADDR_BITS+1 bits).
  typedef logic [DEFAULT_ADDR_BITS:0] count_t;

endpackage

// File: rtl/fifo_sync_prog_if.sv
// Producer/consumer bundle for fifo_sync_prog: write side, read side, status flags.
// Latency: none (wires only).
// Backpressure: producer watches fifo_full, consumer watches fifo_empty / rd_valid.
interface fifo_sync_prog_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_BITS:0]    count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, fifo_full, fifo_empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller only writes when a slot is free.
module fifo_sync_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with count, programmable almost flags, std/FWFT read, flush, error pulses.
// Latency: std mode data 1 cycle after rd_en; FWFT head visible 1 cycle after the write edge.
// Backpressure: writes dropped while full, reads ignored while empty (overflow/underflow pulse).
// Optional: define FIFO_SYNC_PROG_WATERMARK_EN to add the max_count high-water output.
module fifo_sync_prog
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (2**ADDR_BITS) - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic               clk_i,
  input  logic               resetn_i,
  input  logic               clear_i,
  fifo_sync_prog_if.slave    bus
`ifdef FIFO_SYNC_PROG_WATERMARK_EN
  ,
  output logic [ADDR_BITS:0] max_count
`endif
);
  localparam int PTR_W = ptr_width(ADDR_BITS);
  typedef logic [PTR_W-1:0] ptr_t;

  if (!af_thresh_ok(AF_THRESH, ADDR_BITS)) begin : g_bad_af
    $error("fifo_sync_prog: AF_THRESH out of range 1..DEPTH");
  end
  if (!ae_thresh_ok(AE_THRESH, ADDR_BITS)) begin : g_bad_ae
    $error("fifo_sync_prog: AE_THRESH out of range 0..DEPTH-1");
  end

  ptr_t                  w_ptr, r_ptr, occ;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags and count come only from registered pointers.
  assign occ              = w_ptr - r_ptr;
  assign bus.count        = occ;
  assign bus.fifo_empty   = (w_ptr == r_ptr);
  assign bus.fifo_full    = (w_ptr[ADDR_BITS] != r_ptr[ADDR_BITS]) &&
                            (w_ptr[ADDR_BITS-1:0] == r_ptr[ADDR_BITS-1:0]);
  assign bus.almost_full  = (occ >= ptr_t'(AF_THRESH));
  assign bus.almost_empty = (occ <= ptr_t'(AE_THRESH));

  // No pass-through: a full FIFO refuses the write even if a read frees a slot this cycle.
  assign wr_acc = bus.wr_en && !bus.fifo_full;
  assign rd_acc = bus.rd_en && !bus.fifo_empty;

  fifo_sync_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_ram (
    .clk_i (clk_i),
    .we    (wr_acc && !clear_i),
    .waddr (w_ptr[ADDR_BITS-1:0]),
    .wdata (bus.wr_data),
    .raddr (r_ptr[ADDR_BITS-1:0]),
    .rdata (ram_rdata)
  );

  // Pointer update; flush wins over any request in the same cycle.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else if (clear_i) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + ptr_t'(1);
      if (rd_acc) r_ptr <= r_ptr + ptr_t'(1);
    end
  end

  // Error pulses are reported one cycle late and never change FIFO state.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else if (clear_i) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.overflow  <= bus.wr_en && bus.fifo_full;
      bus.underflow <= bus.rd_en && bus.fifo_empty;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word presented directly from the RAM; zero while empty.
    assign bus.rd_valid = !bus.fifo_empty;
    assign bus.rd_data  = bus.fifo_empty ? '0 : ram_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Capture the popped word; rd_data holds until the next accepted read.
    always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (clear_i) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= ram_rdata;
      end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
  end

`ifdef FIFO_SYNC_PROG_WATERMARK_EN
  // High-water mark of registered occupancy; lags count by one cycle.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      max_count <= '0;
    end else if (clear_i) begin
      max_count <= '0;
    end else if (occ > max_count) begin
      max_count <= occ;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench: table of per-cycle vectors on a standard-mode FIFO plus FWFT,
// flush, async reset and (when enabled) high-water sequences.
// Expected values are hand-derived constants; flags are derived from expected count.
module tb_fifo_sync_prog;
  logic clk;
  logic resetn;
  logic clr_a, clr_b;

  fifo_sync_prog_if #(.DATA_WIDTH(8), .ADDR_BITS(2)) ifa ();
  fifo_sync_prog_if #(.DATA_WIDTH(8), .ADDR_BITS(2)) ifb ();

`ifdef FIFO_SYNC_PROG_WATERMARK_EN
  logic [2:0] mca, mcb;
`endif

  fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_BITS(2), .FWFT(0)) dut_a (
    .clk_i    (clk),
    .resetn_i (resetn),
    .clear_i  (clr_a),
    .bus      (ifa)
`ifdef FIFO_SYNC_PROG_WATERMARK_EN
    ,
    .max_count (mca)
`endif
  );

  fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_BITS(2), .FWFT(1)) dut_b (
    .clk_i    (clk),
    .resetn_i (resetn),
    .clear_i  (clr_b),
    .bus      (ifb)
`ifdef FIFO_SYNC_PROG_WATERMARK_EN
    ,
    .max_count (mcb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       clr, we, re;
    logic [7:0] wd;
    logic [2:0] cnt;
    logic       full, empty, af, ae;
    logic       rv;
    logic       chk_rd;
    logic [7:0] rd;
    logic       ovf, unf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags follow from count with AF_THRESH=2, AE_THRESH=1, DEPTH=4.
  task automatic add(input logic clr, input logic we, input logic re, input logic [7:0] wd,
                     input int cnt, input logic rv, input logic chk_rd, input logic [7:0] rd,
                     input logic ovf, input logic unf);
    vec_t v;
    v.clr = clr; v.we = we; v.re = re; v.wd = wd;
    v.cnt = 3'(cnt);
    v.full = (cnt == 4); v.empty = (cnt == 0);
    v.af = (cnt >= 2);   v.ae = (cnt <= 1);
    v.rv = rv; v.chk_rd = chk_rd; v.rd = rd; v.ovf = ovf; v.unf = unf;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.wr_en = 0; ifa.rd_en = 0; ifa.wr_data = 0; clr_a = 0;
    ifb.wr_en = 0; ifb.rd_en = 0; ifb.wr_data = 0; clr_b = 0;
  endtask

  initial begin
    resetn = 1'b1;
    idle_inputs();
    #1 resetn = 1'b0;
    #2;
    // Reset state of both instances.
    check("rst_a count", ifa.count, 0);
    check("rst_a empty", ifa.fifo_empty, 1);
    check("rst_a full", ifa.fifo_full, 0);
    check("rst_a ae", ifa.almost_empty, 1);
    check("rst_a af", ifa.almost_full, 0);
    check("rst_a rv", ifa.rd_valid, 0);
    check("rst_a rd", ifa.rd_data, 0);
    check("rst_a ovf", ifa.overflow, 0);
    check("rst_a unf", ifa.underflow, 0);
    check("rst_b rv", ifb.rd_valid, 0);
    check("rst_b rd", ifb.rd_data, 0);
    check("rst_b empty", ifb.fifo_empty, 1);
    @(negedge clk);
    resetn = 1'b1;

    // Fill to full.
    add(0,1,0,8'h11,1,0,0,0,0,0);
    add(0,1,0,8'h22,2,0,0,0,0,0);
    add(0,1,0,8'h33,3,0,0,0,0,0);
    add(0,1,0,8'h44,4,0,0,0,0,0);
    // Write while full: dropped, overflow pulse for one cycle.
    add(0,1,0,8'h55,4,0,0,0,1,0);
    add(0,0,0,8'h00,4,0,0,0,0,0);
    // Drain in order; 0x55 must never appear.
    add(0,0,1,8'h00,3,1,1,8'h11,0,0);
    add(0,0,1,8'h00,2,1,1,8'h22,0,0);
    add(0,0,1,8'h00,1,1,1,8'h33,0,0);
    add(0,0,1,8'h00,0,1,1,8'h44,0,0);
    // Read while empty: underflow, rd_valid low, rd_data holds.
    add(0,0,1,8'h00,0,0,1,8'h44,0,1);
    add(0,0,0,8'h00,0,0,0,0,0,0);
    // Read+write on empty: only the write lands.
    add(0,1,1,8'h66,1,0,0,0,0,1);
    add(0,0,1,8'h00,0,1,1,8'h66,0,0);
    // Steady R/W at count 2 for 10 cycles, pointers wrap repeatedly.
    add(0,1,0,8'hA0,1,0,0,0,0,0);
    add(0,1,0,8'hA1,2,0,0,0,0,0);
    for (int k = 0; k < 10; k++)
      add(0,1,1,8'(8'hA2 + k),2,1,1,8'(8'hA0 + k),0,0);
    add(0,0,1,8'h00,1,1,1,8'hAA,0,0);
    add(0,0,1,8'h00,0,1,1,8'hAB,0,0);
    // Full with simultaneous R/W: read taken, write refused.
    add(0,1,0,8'hC0,1,0,0,0,0,0);
    add(0,1,0,8'hC1,2,0,0,0,0,0);
    add(0,1,0,8'hC2,3,0,0,0,0,0);
    add(0,1,0,8'hC3,4,0,0,0,0,0);
    add(0,1,1,8'hCC,3,1,1,8'hC0,1,0);
    add(0,0,1,8'h00,2,1,1,8'hC1,0,0);
    add(0,0,1,8'h00,1,1,1,8'hC2,0,0);
    add(0,0,1,8'h00,0,1,1,8'hC3,0,0);
    // Flush at count 3 with a concurrent write: everything discarded.
    add(0,1,0,8'hD0,1,0,0,0,0,0);
    add(0,1,0,8'hD1,2,0,0,0,0,0);
    add(0,1,0,8'hD2,3,0,0,0,0,0);
    add(1,1,0,8'hDD,0,0,0,0,0,0);
    add(0,0,1,8'h00,0,0,0,0,0,1);
    add(0,0,0,8'h00,0,0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      clr_a = v.clr; ifa.wr_en = v.we; ifa.rd_en = v.re; ifa.wr_data = v.wd;
      step();
      check($sformatf("v%0d count", i), ifa.count, v.cnt);
      check($sformatf("v%0d full", i), ifa.fifo_full, v.full);
      check($sformatf("v%0d empty", i), ifa.fifo_empty, v.empty);
      check($sformatf("v%0d af", i), ifa.almost_full, v.af);
      check($sformatf("v%0d ae", i), ifa.almost_empty, v.ae);
      check($sformatf("v%0d rv", i), ifa.rd_valid, v.rv);
      if (v.chk_rd) check($sformatf("v%0d rd", i), ifa.rd_data, v.rd);
      check($sformatf("v%0d ovf", i), ifa.overflow, v.ovf);
      check($sformatf("v%0d unf", i), ifa.underflow, v.unf);
    end
    idle_inputs();

`ifdef FIFO_SYNC_PROG_WATERMARK_EN
    // Earlier fill reached 4; clear, then fill to 3 and drain.
    check("wm before clear", mca, 4);
    clr_a = 1; step(); clr_a = 0;
    check("wm after clear", mca, 0);
    ifa.wr_en = 1;
    ifa.wr_data = 8'hF0; step();
    ifa.wr_data = 8'hF1; step();
    ifa.wr_data = 8'hF2; step();
    check("wm lag", mca, 2);
    ifa.wr_en = 0; ifa.rd_en = 1;
    step(); step(); step();
    ifa.rd_en = 0; step();
    check("wm count0", ifa.count, 0);
    check("wm max3", mca, 3);
    clr_a = 1; step(); clr_a = 0;
    check("wm clear", mca, 0);
`endif

    // FWFT: head appears without rd_en, pop empties and zeroes data.
    ifb.wr_en = 1; ifb.wr_data = 8'hA5; step();
    ifb.wr_en = 0;
    check("fwft rv", ifb.rd_valid, 1);
    check("fwft rd", ifb.rd_data, 8'hA5);
    step();
    check("fwft hold rv", ifb.rd_valid, 1);
    check("fwft hold rd", ifb.rd_data, 8'hA5);
    ifb.rd_en = 1; step(); ifb.rd_en = 0;
    check("fwft pop rv", ifb.rd_valid, 0);
    check("fwft pop rd", ifb.rd_data, 0);
    check("fwft pop empty", ifb.fifo_empty, 1);
    ifb.wr_en = 1; ifb.wr_data = 8'hB1; step();
    ifb.wr_data = 8'hB2; step();
    ifb.wr_en = 0;
    check("fwft head", ifb.rd_data, 8'hB1);
    check("fwft cnt2", ifb.count, 2);
    ifb.rd_en = 1; step();
    check("fwft next", ifb.rd_data, 8'hB2);
    check("fwft cnt1", ifb.count, 1);
    step();
    check("fwft drained rv", ifb.rd_valid, 0);
    step();
    ifb.rd_en = 0;
    check("fwft unf", ifb.underflow, 1);
    check("fwft unf rv", ifb.rd_valid, 0);

    // Async reset mid-burst, between clock edges.
    ifa.wr_en = 1; ifa.wr_data = 8'hE0;
    ifb.wr_en = 1; ifb.wr_data = 8'hE0;
    step();
    ifa.rd_en = 1; ifa.wr_data = 8'hE1; ifb.wr_data = 8'hE1;
    step();
    check("pre-rst rv", ifa.rd_valid, 1);
    check("pre-rst rd", ifa.rd_data, 8'hE0);
    check("pre-rst b cnt", ifb.count, 2);
    #2 resetn = 1'b0;
    #1;
    check("arst count", ifa.count, 0);
    check("arst empty", ifa.fifo_empty, 1);
    check("arst rv", ifa.rd_valid, 0);
    check("arst rd", ifa.rd_data, 0);
    check("arst ae", ifa.almost_empty, 1);
    check("arst b count", ifb.count, 0);
    check("arst b rv", ifb.rd_valid, 0);
    check("arst b rd", ifb.rd_data, 0);
`ifdef FIFO_SYNC_PROG_WATERMARK_EN
    check("arst b wm", mcb, 0);
`endif
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    step();
    check("post-rst empty", ifa.fifo_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_sync_prog.md
Name: fifo_sync_prog

Overview:
Parametrised next-generation synchronous FIFO for single-clock datapaths. Adds the following over the baseline FIFO:
- full DEPTH usage via wrap-bit pointers
- occupancy count
- programmable almost-full/almost-empty flags
- selectable standard or first-word-fall-through (FWFT) read mode
- synchronous flush
- overflow/underflow error pulses

Drop-in buffer between producer/consumer stages in the same clock domain.

Parameters:
DATA_WIDTH, 32, width of each stored word
ADDR_BITS, 4, log2 of depth; DEPTH = 2**ADDR_BITS, ADDR_BITS >= 1
FWFT, 0, 0 = standard read (data one cycle after rd_en), 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH; legal 1..DEPTH
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH; legal 0..DEPTH-1

Ports:
clk_i  in  1  single clock, rising edge
resetn_i  in  1  reset; asynchronous assert, active-low
clear_i  in  1  synchronous flush
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read request (pop/ack in FWFT)
rd_data  out  DATA_WIDTH  read word
rd_valid  out  1  rd_data holds a valid popped/head word
fifo_full  out  1  count == DEPTH
fifo_empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  ADDR_BITS+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write attempted while full
underflow  out  1  one-cycle pulse: read attempted while empty

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low on resetn_i.
- Reset state:
  - pointers = 0, count = 0
  - fifo_empty = 1, fifo_full = 0
  - almost_empty = 1; almost_full = 0 (AF_THRESH >= 1)
  - rd_data = 0, rd_valid = 0
  - overflow = 0, underflow = 0
  - storage array is not reset.
- Pointers: w_ptr/r_ptr are ADDR_BITS+1 wide; low bits address memory, MSB is the wrap bit.
  - empty: pointers equal
  - full: MSBs differ and low bits equal
  - count = w_ptr - r_ptr, modulo 2**(ADDR_BITS+1)
- Write accepted iff wr_en && !fifo_full: mem[w_ptr] <= wr_data, w_ptr++. No pass-through while full, even if a read occurs in the same cycle.
- Read accepted iff rd_en && !fifo_empty: r_ptr++.
- Simultaneous accepted read and write: both occur, count unchanged. On an empty FIFO only the write is accepted.
- Standard mode (FWFT=0):
  - rd_data <= mem[r_ptr] on the accepted read; rd_valid pulses 1 on the following cycle.
  - rd_data holds its last value otherwise.
- FWFT mode:
  - rd_valid = !fifo_empty; rd_data = mem[r_ptr] when non-empty, 0 when empty.
  - Written word visible one cycle after the write edge.
  - rd_en pops the head.
- Flags and count derive from registered pointers only; no combinational path from wr_en/rd_en.
- clear_i: pointers <= 0 next edge, overriding wr_en/rd_en that cycle. Also clears rd_valid, overflow and underflow.
- Error pulses: overflow <= wr_en && fifo_full; underflow <= rd_en && fifo_empty. Registered, one cycle late, and neither affects state.
- Wrap-around: pointers roll over naturally; all DEPTH entries usable.

Optional Feature:
Macro FIFO_SYNC_PROG_WATERMARK_EN.
- Defined: adds output max_count (ADDR_BITS+1).
  - Holds the highest count since reset/clear; updates registered, one cycle after count changes.
  - Reset/clear value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package fifo_sync_pkg holds:
  - function computing pointer width
  - threshold legality checks, used by elaboration assertions
  - typedef for the count type (ADDR_BITS+1 bits)
- One sub-module fifo_sync_ram: DEPTH x DATA_WIDTH storage with one synchronous write port and one asynchronous read port. Pointer, flag and read-mode logic stay in fifo_sync_prog.

Test Plan:
1. Fill/drain, DATA_WIDTH=8, ADDR_BITS=2, FWFT=0. Write 0x11,0x22,0x33,0x44 -> fifo_full=1, count=4, almost_full=1. Read 4 -> rd_data 0x11..0x44 each one cycle after rd_en, then fifo_empty=1.
2. Overflow/underflow. Write 0x55 while full -> overflow pulses 1 cycle, contents unchanged. Read while empty -> underflow pulses, rd_valid stays 0.
3. Simultaneous R/W at count=2 for 10 cycles -> count stays 2, pointers wrap ≥2 times, data order preserved.
4. FWFT=1. Write 0xA5 to empty FIFO -> next cycle rd_valid=1, rd_data=0xA5 with no rd_en. Assert rd_en -> rd_valid=0, rd_data=0.
5. clear_i with count=3 and wr_en=1 the same cycle -> count=0, fifo_empty=1, written word discarded. Async resetn_i low mid-burst -> all outputs to reset values immediately, without waiting for a clock edge.
6. With FIFO_SYNC_PROG_WATERMARK_EN: fill to 3, drain to 0 -> max_count=3; clear_i -> max_count=0.
